// File: rtl/ctu_mon_ctl.sv
// ctu_mon_ctl: arms a bank of CTU level monitors, flags hi/lo toggles seen
// while armed, and drains the failure reports one at a time over a shared
// valid/ready channel using round-robin arbitration.
module ctu_mon_ctl #(
    parameter int          NUM_MON      = 8,
    parameter int          SETTLE_CYC   = 16,
    parameter logic [31:0] MON_NUM_BASE = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 win_req,
    input  logic                 mon_off,
    input  logic [2*NUM_MON-1:0] lvl,
    input  logic                 rpt_ready,
    output logic                 rpt_valid,
    output logic [31:0]          rpt_id,
    output logic                 mon_en,
    output logic [1:0]           state,
    output logic [7:0]           err_cnt
);

    // A settle length of zero behaves exactly like a single cycle.
    localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam int PTR_W      = $clog2(NUM_MON);
    localparam int POP_W      = $clog2(NUM_MON + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ARMED  = 2'd2,
        ST_WINDOW = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [2*NUM_MON-1:0] r_lvl_hist;
    logic [NUM_MON-1:0]   r_pend;
    logic [NUM_MON-1:0]   w_tog;
    logic [NUM_MON-1:0]   w_viol;
    logic [NUM_MON-1:0]   w_grant_clr;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_winner;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic                 w_load;
    logic [POP_W-1:0]     w_viol_cnt;
    logic [8:0]           w_err_sum;

    assign state  = r_state;
    assign mon_en = (r_state == ST_ARMED);

    // State register and settle counter.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; stop overrides everything, including start.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which
        // would otherwise infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (win_req)
                        w_state_nxt = ST_WINDOW;
                    else if (r_cnt == CNT_W'(SETTLE_EFF - 1))
                        w_state_nxt = ST_ARMED;
                    else
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                ST_ARMED: begin
                    if (win_req)
                        w_state_nxt = ST_WINDOW;
                end
                ST_WINDOW: begin
                    if (!win_req) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Toggle detection: any bit of a pair differing from last cycle's sample.
    always_comb begin
        w_viol_cnt = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            w_tog[i] = |(r_lvl_hist[2*i +: 2] ^ lvl[2*i +: 2]);
        end
        w_viol = (r_state == ST_ARMED && !mon_off) ? w_tog : '0;
        for (int i = 0; i < NUM_MON; i++) begin
            w_viol_cnt = w_viol_cnt + POP_W'(w_viol[i]);
        end
        w_err_sum = {1'b0, err_cnt} + 9'(w_viol_cnt);
    end

    // Round-robin pick: first pending index at or after the pointer, wrapping.
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_MON; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_MON)
                idx = idx - NUM_MON;
            if (!found && r_pend[idx]) begin
                found    = 1'b1;
                w_winner = PTR_W'(idx);
            end
        end
        w_ptr_nxt   = (w_winner == PTR_W'(NUM_MON - 1)) ? '0 : w_winner + PTR_W'(1);
        w_load      = (!rpt_valid || rpt_ready) && (|r_pend);
        w_grant_clr = w_load ? ({{(NUM_MON-1){1'b0}}, 1'b1} << w_winner) : '0;
    end

    // Level history, pending set/clear, report channel and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl_hist <= '0;
            r_pend     <= '0;
            r_ptr      <= '0;
            rpt_valid  <= 1'b0;
            rpt_id     <= '0;
            err_cnt    <= '0;
        end else begin
            r_lvl_hist <= lvl;
            // A fresh violation on the bit being granted wins over the clear.
            r_pend     <= (r_pend & ~w_grant_clr) | w_viol;
            err_cnt    <= (w_err_sum > 9'd255) ? 8'hFF : w_err_sum[7:0];
            if (w_load) begin
                rpt_valid <= 1'b1;
                rpt_id    <= MON_NUM_BASE + 32'(w_winner);
                r_ptr     <= w_ptr_nxt;
            end else if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctu_mon_ctl.sv
// Bench for ctu_mon_ctl: directed scenarios, a cycle-level reference model
// compared on every falling edge, and literal checks at key points.
module tb_ctu_mon_ctl;

    localparam int          N    = 8;
    localparam int          SC   = 16;
    localparam logic [31:0] BASE = 32'h100;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stop;
    logic           win_req;
    logic           mon_off;
    logic [2*N-1:0] lvl;
    logic           rpt_ready;
    logic           rpt_valid;
    logic [31:0]    rpt_id;
    logic           mon_en;
    logic [1:0]     state;
    logic [7:0]     err_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          m_state;
    int          m_cnt;
    int          m_ptr;
    int          m_err;
    bit [N-1:0]  m_pend;
    bit          m_valid;
    logic [31:0] m_id;
    logic [2*N-1:0] m_hist;
    bit [N-1:0]  mv_viol;
    int          mv_n;
    int          mv_win;
    bit          mv_found;

    always #5 clk = ~clk;

    ctu_mon_ctl #(
        .NUM_MON      (N),
        .SETTLE_CYC   (SC),
        .MON_NUM_BASE (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .win_req   (win_req),
        .mon_off   (mon_off),
        .lvl       (lvl),
        .rpt_ready (rpt_ready),
        .rpt_valid (rpt_valid),
        .rpt_id    (rpt_id),
        .mon_en    (mon_en),
        .state     (state),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: applies the controller rules to pre-edge inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_cnt = 0; m_ptr = 0; m_err = 0;
            m_pend = '0; m_valid = 1'b0; m_id = '0; m_hist = '0;
        end else begin
            mv_viol = '0;
            mv_n    = 0;
            for (int i = 0; i < N; i++) begin
                if (m_state == 2 && !mon_off && lvl[2*i +: 2] != m_hist[2*i +: 2]) begin
                    mv_viol[i] = 1'b1;
                    mv_n++;
                end
            end
            if (!m_valid || rpt_ready) begin
                if (m_pend != '0) begin
                    mv_found = 1'b0;
                    mv_win   = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!mv_found && m_pend[(m_ptr + k) % N]) begin
                            mv_found = 1'b1;
                            mv_win   = (m_ptr + k) % N;
                        end
                    end
                    m_valid = 1'b1;
                    m_id    = BASE + mv_win;
                    m_pend[mv_win] = 1'b0;
                    m_ptr   = (mv_win + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_pend = m_pend | mv_viol;
            m_err  = (m_err + mv_n > 255) ? 255 : m_err + mv_n;
            m_hist = lvl;
            if (stop) m_state = 0;
            else if (m_state == 0) begin
                if (start) begin m_state = 1; m_cnt = 0; end
            end else if (m_state == 1) begin
                if (win_req) m_state = 3;
                else if (m_cnt == SC - 1) m_state = 2;
                else m_cnt++;
            end else if (m_state == 2) begin
                if (win_req) m_state = 3;
            end else begin
                if (!win_req) begin m_state = 1; m_cnt = 0; end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("cmp_state", 32'(state), m_state);
            check("cmp_mon_en", 32'(mon_en), (m_state == 2) ? 1 : 0);
            check("cmp_valid", 32'(rpt_valid), 32'(m_valid));
            if (m_valid) check("cmp_id", rpt_id, m_id);
            check("cmp_err", 32'(err_cnt), m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; win_req = 1'b0;
        mon_off = 1'b0; rpt_ready = 1'b0; lvl = '0;
        tick(3);
        check("rst_state", 32'(state), 0);
        check("rst_mon_en", 32'(mon_en), 0);
        check("rst_valid", 32'(rpt_valid), 0);
        check("rst_id", rpt_id, 0);
        check("rst_err", 32'(err_cnt), 0);
        rst = 1'b0;

        // Bring-up: 16 cycles in SETTLE, toggles there are absorbed.
        start = 1'b1; tick(1); start = 1'b0;
        check("settle_entry", 32'(state), 1);
        lvl[0] = 1'b1;
        tick(15);
        check("settle_last", 32'(state), 1);
        check("settle_err", 32'(err_cnt), 0);
        check("settle_valid", 32'(rpt_valid), 0);
        tick(1);
        check("armed_state", 32'(state), 2);
        check("armed_mon_en", 32'(mon_en), 1);

        // Round robin from pointer 0: pairs 0, 2, 7.
        rpt_ready = 1'b1;
        lvl[0] = ~lvl[0]; lvl[4] = ~lvl[4]; lvl[14] = ~lvl[14];
        tick(1);
        check("rr_valid0", 32'(rpt_valid), 0);
        check("rr_err3", 32'(err_cnt), 3);
        tick(1); check("rr_id0", rpt_id, 32'h100);
        tick(1); check("rr_id2", rpt_id, 32'h102);
        tick(1); check("rr_id7", rpt_id, 32'h107);
        tick(1); check("rr_drained", 32'(rpt_valid), 0);
        lvl[0] = ~lvl[0]; lvl[14] = ~lvl[14];
        tick(1); check("rr2_err5", 32'(err_cnt), 5);
        tick(1); check("rr2_id0", rpt_id, 32'h100);
        tick(1); check("rr2_id7", rpt_id, 32'h107);
        tick(1); check("rr2_drained", 32'(rpt_valid), 0);

        // Single violation on pair 3 hi, held under backpressure.
        rpt_ready = 1'b0;
        lvl[7] = ~lvl[7];
        tick(1);
        check("one_valid_early", 32'(rpt_valid), 0);
        check("one_err", 32'(err_cnt), 6);
        tick(1);
        check("one_valid", 32'(rpt_valid), 1);
        check("one_id", rpt_id, 32'h103);
        tick(5);
        check("hold_valid", 32'(rpt_valid), 1);
        check("hold_id", rpt_id, 32'h103);
        rpt_ready = 1'b1;
        tick(1);
        check("one_done", 32'(rpt_valid), 0);

        // Window: toggles absorbed, then re-settle and re-arm.
        rpt_ready = 1'b1;
        win_req = 1'b1;
        tick(1); check("win_state", 32'(state), 3);
        lvl = ~lvl;
        tick(2);
        check("win_err", 32'(err_cnt), 6);
        check("win_valid", 32'(rpt_valid), 0);
        win_req = 1'b0;
        tick(1); check("resettle", 32'(state), 1);
        tick(15); check("resettle_last", 32'(state), 1);
        tick(1); check("rearmed", 32'(state), 2);
        lvl[10] = ~lvl[10];
        tick(1); check("rearm_err", 32'(err_cnt), 7);
        tick(1); check("rearm_id", rpt_id, 32'h105);
        tick(1); check("rearm_done", 32'(rpt_valid), 0);

        // Suppress: pair 1 toggles are ignored.
        mon_off = 1'b1;
        lvl[2] = ~lvl[2];
        tick(2);
        check("off_err", 32'(err_cnt), 7);
        check("off_valid", 32'(rpt_valid), 0);
        mon_off = 1'b0;

        // Stop beats start; pending reports keep draining in IDLE.
        rpt_ready = 1'b0;
        lvl[8] = ~lvl[8]; lvl[12] = ~lvl[12];
        tick(1); check("stop_err", 32'(err_cnt), 9);
        tick(1); check("stop_id6", rpt_id, 32'h106);
        stop = 1'b1; start = 1'b1;
        tick(1);
        stop = 1'b0; start = 1'b0;
        check("stop_state", 32'(state), 0);
        check("stop_mon_en", 32'(mon_en), 0);
        check("stop_hold", 32'(rpt_valid), 1);
        rpt_ready = 1'b1;
        tick(1);
        check("drain_valid", 32'(rpt_valid), 1);
        check("drain_id4", rpt_id, 32'h104);
        tick(1); check("drain_done", 32'(rpt_valid), 0);

        // Saturation: 300 toggles on pair 5.
        start = 1'b1; tick(1); start = 1'b0;
        tick(16);
        check("sat_armed", 32'(state), 2);
        for (int i = 0; i < 300; i++) begin
            lvl[10] = ~lvl[10];
            tick(1);
        end
        check("sat_err", 32'(err_cnt), 255);
        check("sat_model", m_err, 255);
        check("sat_valid", 32'(rpt_valid), 1);
        rpt_ready = 1'b0;
        tick(1);
        check("pre_rst_valid", 32'(rpt_valid), 1);

        // Asynchronous reset mid-handshake, no clock edge in between.
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 32'(rpt_valid), 0);
        check("arst_state", 32'(state), 0);
        check("arst_err", 32'(err_cnt), 0);
        check("arst_id", rpt_id, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("post_rst_state", 32'(state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
